// File: rtl/rv_pkg.sv
// Shared constants and types for the reduced RISC-V integer datapath.
//   D_WIDTH    : data width of each architectural register
//   NREGS      : number of architectural registers (x0 hardwired to zero)
//   A_WIDTH    : register address width, clog2(NREGS)
//   reg_addr_t : register index type
//   word_t     : register data type
//   ZERO_REG   : index of the hardwired-zero register
package rv_pkg;

  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned A_WIDTH = 5;

  typedef logic [A_WIDTH-1:0] reg_addr_t;
  typedef logic [D_WIDTH-1:0] word_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst_n                 : core clock, async active-low reset
//   rs1_addr, rs2_addr         : source registers of the presented instruction
//   wb_valid, wb_addr          : writeback strobe/destination (clears pending)
//   issue_valid, issue_rd      : presented instruction and its destination
//   issue_rd_used/rs1/rs2_used : operand usage qualifiers
//   stall                      : presented instruction must be held
//   pending_cnt                : registered count of pending registers
module rf_scoreboard #(
  parameter int unsigned NREGS   = rv_pkg::NREGS,
  parameter int unsigned A_WIDTH = rv_pkg::A_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] rs1_addr,
  input  logic [A_WIDTH-1:0] rs2_addr,
  input  logic               wb_valid,
  input  logic [A_WIDTH-1:0] wb_addr,
  input  logic               issue_valid,
  input  logic [A_WIDTH-1:0] issue_rd,
  input  logic               issue_rd_used,
  input  logic               issue_rs1_used,
  input  logic               issue_rs2_used,
  output logic               stall,
  output logic [A_WIDTH:0]   pending_cnt
);

  import rv_pkg::*;

  logic [NREGS-1:0] pending_q, pending_d;
  logic [A_WIDTH:0] cnt_q, cnt_d;
  logic             raw1, raw2, waw, accept;

  // A writeback landing this cycle resolves the hazard on its register.
  always_comb begin
    raw1   = issue_rs1_used && pending_q[rs1_addr] && !(wb_valid && (wb_addr == rs1_addr));
    raw2   = issue_rs2_used && pending_q[rs2_addr] && !(wb_valid && (wb_addr == rs2_addr));
    waw    = issue_rd_used  && pending_q[issue_rd] && !(wb_valid && (wb_addr == issue_rd));
    stall  = issue_valid && (raw1 || raw2 || waw);
    accept = issue_valid && !stall;
  end

  // Clear first, then set, so a newly issued write to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)
      pending_d[wb_addr] = 1'b0;
    if (accept && issue_rd_used && (issue_rd != A_WIDTH'(ZERO_REG)))
      pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_d = cnt_d + {{A_WIDTH{1'b0}}, pending_d[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_wb.sv
// Integer register file with writeback endpoint and hazard scoreboard.
//   clk, rst_n          : core clock, async active-low reset
//   rs1_addr/rs1_data   : read port 1 (to ALU aluop1), combinational
//   rs2_addr/rs2_data   : read port 2 (to ALU regop2), combinational
//   wb_valid/addr/data  : writeback port (ALU or multicycle results)
//   issue_*             : presented instruction for hazard checking
//   stall               : presented instruction is held
//   pending_cnt         : number of registers with writes outstanding
module regfile_wb #(
  parameter int unsigned D_WIDTH = rv_pkg::D_WIDTH,
  parameter int unsigned NREGS   = rv_pkg::NREGS,
  parameter int unsigned A_WIDTH = rv_pkg::A_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] rs1_addr,
  input  logic [A_WIDTH-1:0] rs2_addr,
  output logic [D_WIDTH-1:0] rs1_data,
  output logic [D_WIDTH-1:0] rs2_data,
  input  logic               wb_valid,
  input  logic [A_WIDTH-1:0] wb_addr,
  input  logic [D_WIDTH-1:0] wb_data,
  input  logic               issue_valid,
  input  logic [A_WIDTH-1:0] issue_rd,
  input  logic               issue_rd_used,
  input  logic               issue_rs1_used,
  input  logic               issue_rs2_used,
  output logic               stall,
  output logic [A_WIDTH:0]   pending_cnt
);

  import rv_pkg::*;

  logic [D_WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wb_valid && (wb_addr != A_WIDTH'(ZERO_REG))) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Bypass is gated by rst_n so reads stay zero for the whole reset window.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n && (rs1_addr != A_WIDTH'(ZERO_REG)))
      rs1_data = (wb_valid && (wb_addr == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    if (rst_n && (rs2_addr != A_WIDTH'(ZERO_REG)))
      rs2_data = (wb_valid && (wb_addr == rs2_addr)) ? wb_data : regs_q[rs2_addr];
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .A_WIDTH (A_WIDTH)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rd_used  (issue_rd_used),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .stall          (stall),
    .pending_cnt    (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid, issue_valid, issue_rd_used, issue_rs1_used, issue_rs2_used;
  logic        stall;
  logic [5:0]  pending_cnt;

  always #5 clk = ~clk;

  regfile_wb #(.D_WIDTH(32), .NREGS(32), .A_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rd_used  (issue_rd_used),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .stall          (stall),
    .pending_cnt    (pending_cnt)
  );

  typedef struct {
    string       name;
    bit          c1;
    logic [31:0] e1;
    bit          c2;
    logic [31:0] e2;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  event chk_ev;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
  endtask

  // Monitor: outputs are sampled on the falling edge, or on demand for
  // checks that must happen without a clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.c1) chk({e.name, ".rs1"}, rs1_data, e.e1);
        if (e.c2) chk({e.name, ".rs2"}, rs2_data, e.e2);
        chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.st});
        chk({e.name, ".cnt"}, {26'd0, pending_cnt}, {26'd0, e.cnt});
      end
    end
  end

  task automatic expect_(input string n, input bit c1, input logic [31:0] e1,
                         input bit c2, input logic [31:0] e2,
                         input logic st, input logic [5:0] cnt);
    exp_t e;
    e.name = n; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] rd, input logic rdu,
                     input logic r1u, input logic r2u,
                     input logic [4:0] a1, input logic [4:0] a2);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    issue_valid = iv; issue_rd = rd; issue_rd_used = rdu;
    issue_rs1_used = r1u; issue_rs2_used = r2u;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held: reads zero even with a writeback presented.
    tick(); set(1, 5, 32'hAAAA_AAAA, 0, 0, 0, 0, 0, 5, 31);
    expect_("rst_hold", 1, 0, 1, 0, 0, 0);
    tick(); rst_n = 1'b1; set(0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
    expect_("rst_read", 1, 0, 1, 0, 0, 0);

    // Write with same-cycle bypass, then stored value.
    tick(); set(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3, 31);
    expect_("bypass", 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 0, 3, 5);
    expect_("stored", 1, 32'hDEAD_BEEF, 1, 0, 0, 0);

    // x0 protection.
    tick(); set(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 3);
    expect_("x0_wr", 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    expect_("x0_after", 1, 0, 1, 32'hDEAD_BEEF, 0, 0);

    // RAW stall and release on writeback.
    tick(); set(0, 0, 0, 1, 7, 1, 0, 0, 0, 0);
    expect_("iss_rd7", 0, 0, 0, 0, 0, 0);
    tick(); set(0, 0, 0, 1, 0, 0, 1, 0, 7, 0);
    expect_("raw7_a", 0, 0, 0, 0, 1, 1);
    tick();
    expect_("raw7_b", 0, 0, 0, 0, 1, 1);
    tick(); set(1, 7, 32'h12, 1, 0, 0, 1, 0, 7, 0);
    expect_("raw7_wb", 1, 32'h12, 0, 0, 0, 1);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    expect_("raw7_done", 1, 32'h12, 0, 0, 0, 0);

    // Simultaneous set/clear on reg 9: set wins.
    tick(); set(0, 0, 0, 1, 9, 1, 0, 0, 0, 0);
    expect_("iss_rd9", 0, 0, 0, 0, 0, 0);
    tick(); set(1, 9, 32'h99, 1, 9, 1, 0, 0, 0, 0);
    expect_("setclr9", 0, 0, 0, 0, 0, 1);
    tick(); set(0, 0, 0, 1, 0, 0, 0, 1, 0, 9);
    expect_("raw9_rs2", 0, 0, 1, 32'h99, 1, 1);
    tick(); set(0, 0, 0, 1, 9, 1, 0, 0, 0, 9);
    expect_("waw9", 0, 0, 1, 32'h99, 1, 1);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 1, 0, 9);
    expect_("noissue", 0, 0, 1, 32'h99, 0, 1);
    tick(); set(1, 9, 32'h77, 0, 0, 0, 0, 0, 0, 9);
    expect_("wb9", 0, 0, 1, 32'h77, 0, 1);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    expect_("wb9_done", 0, 0, 1, 32'h77, 0, 0);

    // Async reset with hazards in flight.
    tick(); set(1, 2, 32'h55, 1, 2, 1, 0, 0, 0, 0);
    expect_("iss_rd2", 0, 0, 0, 0, 0, 0);
    tick(); set(0, 0, 0, 1, 4, 1, 0, 0, 0, 0);
    expect_("iss_rd4", 0, 0, 0, 0, 0, 1);
    tick(); set(0, 0, 0, 1, 6, 1, 0, 0, 0, 0);
    expect_("iss_rd6", 0, 0, 0, 0, 0, 2);
    tick(); set(0, 0, 0, 1, 0, 0, 1, 0, 2, 0);
    expect_("raw2", 1, 32'h55, 0, 0, 1, 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 expect_("async_rst", 1, 0, 0, 0, 0, 0);
    ->chk_ev;

    // Writeback after release is stored; old hazards are gone.
    tick(); rst_n = 1'b1; set(1, 4, 32'hABC, 1, 0, 0, 1, 1, 4, 6);
    expect_("post_rst", 1, 32'hABC, 1, 0, 0, 0);
    tick(); set(0, 0, 0, 0, 0, 0, 0, 0, 4, 2);
    expect_("post_rd", 1, 32'hABC, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
